piso_bit_serializer: RTL and testbench
======================================

// Module: piso_bit_serializer
// PURPOSE
//  Parallel-in/serial-out feeder placed directly upstream of the serial "001" sequence detector.
//  Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clk on bit_out.
//  bit_out drives the detector's serial input. bit_valid qualifies each bit.
//  Idle line level is IDLE_BIT so the detector sees no spurious zeros between words.
// PARAMETERS
//  WIDTH       8  word width in bits; legal range 2..32
//  MSB_FIRST   1  1: din[WIDTH-1] is shifted out first; 0: din[0] is shifted out first
//  IDLE_BIT    1  level driven on bit_out whenever no word bit is being sent (idle, gap, reset)
//  GAP_CYCLES  0  idle-level cycles inserted after each word; legal range 0..15
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  din        in   WIDTH  parallel word
//  din_valid  in   1      din holds a word to send
//  din_ready  out  1      serializer can accept a word this cycle; transfer when din_valid & din_ready
//  bit_out    out  1      serial data, registered
//  bit_valid  out  1      bit_out carries a word bit, registered
//  word_done  out  1      one-cycle pulse, coincident with the last bit of a word, registered
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync-to-clk release by the system):
//   - state=IDLE, shift reg all IDLE_BIT, bit_out=IDLE_BIT, bit_valid=0, word_done=0, counters=0.
//   - din_ready=0 while reset is high.
//   - Reset mid-word abandons the word. The next posedge after release sees IDLE.
//  FSM states: IDLE, SHIFT, GAP.
//   - IDLE:
//     - din_ready=1.
//     - On accept, load shreg (bit-reversed when MSB_FIRST=0), set bitcnt=WIDTH-1, go to SHIFT.
//     - Otherwise stay in IDLE.
//   - SHIFT:
//     - bit_valid=1, one bit per cycle.
//     - Shift in IDLE_BIT at the vacated end; decrement bitcnt.
//     - While bitcnt==0 (last bit on bit_out): word_done=1.
//     - Exit when GAP_CYCLES>0: go to GAP, gapcnt=GAP_CYCLES-1.
//     - Exit when GAP_CYCLES==0: din_ready=1 in the last-bit cycle. On accept, reload and stay in SHIFT (zero-bubble streaming). Otherwise go to IDLE.
//   - GAP:
//     - bit_out=IDLE_BIT, bit_valid=0, din_ready=0.
//     - Decrement gapcnt; at 0, go to IDLE.
//  Latency: word accepted at edge k puts its first bit on bit_out/bit_valid after edge k.
//  The word occupies exactly WIDTH consecutive cycles.
//  Handshake rules:
//   - din is sampled only on transfer.
//   - din_valid while din_ready=0 is held off, never dropped or captured.
//   - din_ready is combinational from state/bitcnt only, never from din_valid.
//  Widths: bitcnt is $clog2(WIDTH) bits; gapcnt is 4 bits. No wrap: counters are only loaded on transitions.
//  Outside SHIFT: bit_out=IDLE_BIT and bit_valid=0 in every cycle.
// STRUCTURE
//  Shared package serial_pkg: state enum {IDLE,SHIFT,GAP} (2-bit) and localparam IDLE_LEVEL=1'b1.
//  The detector bench reuses both.
//  One sub-module, piso_shreg: WIDTH-bit load/shift register with fill bit.
//  The FSM and counters live in the top.
// TESTING
//  1. Reset asserted mid-cycle -> all outputs are reset values immediately (async). din_ready=0 until release.
//  2. WIDTH=8, MSB_FIRST=1, din=8'h20 -> bit_out 0,0,1,0,0,0,0,0 for 8 cycles with bit_valid=1; word_done on cycle 8; then bit_out=1.
//  3. GAP_CYCLES=0, two words 8'hC9,8'h01 back-to-back -> 16 contiguous bit_valid cycles; word_done on cycles 8 and 16.
//  4. GAP_CYCLES=2 -> exactly 2 cycles with bit_valid=0 and bit_out=1 between words; din_valid held high is not accepted in GAP.
//  5. MSB_FIRST=0, din=8'h01 -> bit_out 1,0,0,0,0,0,0,0.
//  6. Chained to the 001 detector, din=8'hC9 (1,1,0,0,1,0,0,1) -> det=1 during bits 5 and 8 only. Reset at bit 3 -> no det.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types for the serial "001" path.
// Used by the serializer and the detector bench.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/piso_shreg.sv
// Load/shift register, MSB is the serial output.
// The vacated LSB end is refilled with the fill bit.
module piso_shreg
    import serial_pkg::*;
#(
    parameter int   WIDTH = 8,
    parameter logic FILL  = IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_q
);

    logic [WIDTH-1:0] r_sh;

    // Parallel load wins over shift; reset fills with idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh <= {WIDTH{FILL}};
        end else if (i_load) begin
            r_sh <= i_d;
        end else if (i_shift) begin
            r_sh <= {r_sh[WIDTH-2:0], FILL};
        end
    end

    assign o_q = r_sh[WIDTH-1];

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out feeder for the "001" detector.
// Valid/ready word intake, one registered bit per clock.
module piso_bit_serializer
    import serial_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_BIT   = IDLE_LEVEL,
    parameter int   GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_bitcnt;
    logic [CW-1:0] w_bitcnt_nxt;
    logic [3:0]    r_gapcnt;
    logic [3:0]    w_gapcnt_nxt;
    logic          r_bit_valid;
    logic          r_word_done;
    logic          w_ready;
    logic          w_load;
    logic          w_shift;
    logic [WIDTH-1:0] w_word;

    // Present the word so its first bit sits at the MSB of the shifter.
    always_comb begin
        w_word = din;
        if (!MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                w_word[i] = din[WIDTH-1-i];
            end
        end
    end

    // Next-state, counters and handshake for IDLE/SHIFT/GAP.
    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_gapcnt_nxt = r_gapcnt;
        w_ready      = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (din_valid) begin
                    w_load       = 1'b1;
                    w_bitcnt_nxt = LAST_IDX;
                    w_state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                if (r_bitcnt != '0) begin
                    w_shift      = 1'b1;
                    w_bitcnt_nxt = r_bitcnt - 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    w_shift      = 1'b1;
                    w_gapcnt_nxt = GAP_INIT;
                    w_state_nxt  = GAP;
                end else begin
                    w_ready = 1'b1;
                    if (din_valid) begin
                        w_load       = 1'b1;
                        w_bitcnt_nxt = LAST_IDX;
                    end else begin
                        w_shift     = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                // The IDLE handshake cycle is the last idle-level cycle.
                if (r_gapcnt <= 4'd1) begin
                    w_gapcnt_nxt = '0;
                    w_state_nxt  = IDLE;
                end else begin
                    w_gapcnt_nxt = r_gapcnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered bit qualifiers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bitcnt    <= '0;
            r_gapcnt    <= '0;
            r_bit_valid <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_gapcnt    <= w_gapcnt_nxt;
            r_bit_valid <= (w_state_nxt == SHIFT);
            r_word_done <= (w_state_nxt == SHIFT) &&
                           (w_bitcnt_nxt == '0);
        end
    end

    piso_shreg #(
        .WIDTH (WIDTH),
        .FILL  (IDLE_BIT)
    ) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_d     (w_word),
        .o_q     (bit_out)
    );

    assign din_ready = w_ready & ~reset;
    assign bit_valid = r_bit_valid;
    assign word_done = r_word_done;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer.
// Three configurations share clock and reset.
module tb_piso_bit_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [7:0] a_din, b_din, c_din;
    logic a_vld, b_vld, c_vld;
    logic a_rdy, a_bit, a_bv, a_done, a_busy;
    logic b_rdy, b_bit, b_bv, b_done, b_busy;
    logic c_rdy, c_bit, c_bv, c_done, c_busy;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    piso_bit_serializer #(
        .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .GAP_CYCLES(0)
    ) u_a (
        .clk(clk), .reset(reset), .din(a_din), .din_valid(a_vld),
        .din_ready(a_rdy), .bit_out(a_bit), .bit_valid(a_bv),
        .word_done(a_done), .busy(a_busy)
    );

    piso_bit_serializer #(
        .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP_CYCLES(0)
    ) u_b (
        .clk(clk), .reset(reset), .din(b_din), .din_valid(b_vld),
        .din_ready(b_rdy), .bit_out(b_bit), .bit_valid(b_bv),
        .word_done(b_done), .busy(b_busy)
    );

    piso_bit_serializer #(
        .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .GAP_CYCLES(2)
    ) u_c (
        .clk(clk), .reset(reset), .din(c_din), .din_valid(c_vld),
        .din_ready(c_rdy), .bit_out(c_bit), .bit_valid(c_bv),
        .word_done(c_done), .busy(c_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        logic [7:0]  w8;
        logic [15:0] w16;
        logic [1:0]  hist;
        logic        det;
        logic        ev;
        int          nbub;
        int          ndet;

        a_din = '0; b_din = '0; c_din = '0;
        a_vld = 0;  b_vld = 0;  c_vld = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(a_rdy), 0);
        chk("rst_bit", 32'(a_bit), 1);
        chk("rst_bv", 32'(a_bv), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_busy", 32'(a_busy), 0);
        reset = 0;
        @(negedge clk);
        chk("idle_rdy", 32'(a_rdy), 1);
        chk("idle_bit", 32'(a_bit), 1);

        // Single word 8'h20, MSB first
        w8 = 8'h20;
        a_din = w8; a_vld = 1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            a_vld = 0;
            chk("w20_bit", 32'(a_bit), 32'(w8[8-i]));
            chk("w20_bv", 32'(a_bv), 1);
            chk("w20_done", 32'(a_done), 32'(i == 8));
        end
        @(negedge clk);
        chk("w20_tail_bit", 32'(a_bit), 1);
        chk("w20_tail_bv", 32'(a_bv), 0);
        chk("w20_tail_busy", 32'(a_busy), 0);

        // Back-to-back C9,01 with no gap
        w16 = 16'hC901;
        a_din = 8'hC9; a_vld = 1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) a_din = 8'h01;
            if (i == 9) a_vld = 0;
            chk("b2b_bit", 32'(a_bit), 32'(w16[16-i]));
            chk("b2b_bv", 32'(a_bv), 1);
            chk("b2b_done", 32'(a_done), 32'(i == 8 || i == 16));
            chk("b2b_rdy", 32'(a_rdy), 32'(i == 8 || i == 16));
        end
        @(negedge clk);
        chk("b2b_tail_bv", 32'(a_bv), 0);

        // Two-cycle gap, valid held through it
        w16 = 16'hA53C;
        c_din = 8'hA5; c_vld = 1;
        nbub = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 1) c_din = 8'h3C;
            if (i == 11) c_vld = 0;
            ev = (i <= 8) || (i >= 11);
            if (!c_bv) nbub++;
            chk("gap_bv", 32'(c_bv), 32'(ev));
            if (i <= 8)
                chk("gap_bit", 32'(c_bit), 32'(w16[16-i]));
            else if (i >= 11)
                chk("gap_bit", 32'(c_bit), 32'(w16[18-i]));
            else
                chk("gap_idle_bit", 32'(c_bit), 1);
            chk("gap_done", 32'(c_done), 32'(i == 8 || i == 18));
            if (i == 9) chk("gap_rdy_held", 32'(c_rdy), 0);
            if (i == 10) chk("gap_rdy_idle", 32'(c_rdy), 1);
        end
        chk("gap_bubbles", 32'(nbub), 2);
        repeat (3) @(negedge clk);
        chk("gap_end_busy", 32'(c_busy), 0);

        // LSB first, 8'h01
        w8 = 8'h01;
        b_din = w8; b_vld = 1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            b_vld = 0;
            chk("lsb_bit", 32'(b_bit), 32'(w8[i-1]));
            chk("lsb_bv", 32'(b_bv), 1);
        end
        @(negedge clk);
        chk("lsb_tail_bv", 32'(b_bv), 0);

        // Chained 001 detector, C9 -> hits on bits 5 and 8
        hist = 2'b11;
        a_din = 8'hC9; a_vld = 1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            a_vld = 0;
            det = a_bv & a_bit & (hist == 2'b00);
            chk("det_c9", 32'(det), 32'(i == 5 || i == 8));
            if (a_bv) hist = {hist[0], a_bit};
        end
        @(negedge clk);

        // Async reset during bit 3 abandons the word
        hist = 2'b11;
        a_din = 8'hC9; a_vld = 1;
        @(negedge clk);
        a_vld = 0;
        repeat (2) @(negedge clk);
        #2 reset = 1;
        #1;
        chk("arst_bit", 32'(a_bit), 1);
        chk("arst_bv", 32'(a_bv), 0);
        chk("arst_busy", 32'(a_busy), 0);
        chk("arst_rdy", 32'(a_rdy), 0);
        chk("arst_done", 32'(a_done), 0);
        @(negedge clk);
        chk("arst_rdy_hold", 32'(a_rdy), 0);
        reset = 0;
        ndet = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            det = a_bv & a_bit & (hist == 2'b00);
            if (det) ndet++;
            if (a_bv) hist = {hist[0], a_bit};
        end
        chk("arst_no_det", 32'(ndet), 0);
        chk("arst_idle_rdy", 32'(a_rdy), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
